alu_muldiv: RTL and testbench



---
 rtl/alu_muldiv_if.sv | 26 ++
 rtl/alu_muldiv.sv | 176 +++++++++++++++++
 tb/tb_alu_muldiv.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface alu_muldiv_if #(
    parameter int DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] rega;
    logic [DATA_WIDTH-1:0] regb;
    logic [2:0]            op;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] lo;
    logic                  div_by_zero;

    // Pipeline side: issues requests, reads HI/LO and status.
    modport master (
        output rega, regb, op, start,
        input  busy, done, hi, lo, div_by_zero
    );

    // Unit side.
    modport slave (
        input  rega, regb, op, start,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/alu_muldiv.sv
// MIPS I multiply/divide unit: iterative radix-2 engine with HI/LO registers.
// MULT/MULTU/DIV/DIVU take DATA_WIDTH+1 busy cycles; MTHI/MTLO take one edge.
module alu_muldiv #(
    parameter int DATA_WIDTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_muldiv_if.slave  bus
);
    localparam int W        = DATA_WIDTH;
    localparam int CNT_BITS = $clog2(W) + 1;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t                state_reg, state_next;
    logic [CNT_BITS-1:0]   cnt_reg;
    logic [W-1:0]          acc_hi_reg;   // partial product high / running remainder
    logic [W-1:0]          acc_lo_reg;   // multiplier bits / dividend-quotient shifter
    logic [W-1:0]          opb_reg;      // |multiplicand| or |divisor|
    logic [W-1:0]          orig_a_reg;   // raw rega, returned as HI on divide by zero
    logic                  is_div_reg;
    logic                  b_zero_reg;
    logic                  sign_q_reg;   // product / quotient must be negated
    logic                  sign_r_reg;   // remainder must be negated
    logic [W-1:0]          hi_reg, lo_reg;
    logic                  done_reg;
    logic                  dbz_reg;

    logic                  accept;
    logic                  a_neg, b_neg;
    logic [W-1:0]          a_abs, b_abs;
    logic [W:0]            mul_sum;
    logic [W+1:0]          div_diff;
    logic [2*W-1:0]        prod_fixed;
    logic [W-1:0]          fix_hi, fix_lo;

    // An arithmetic request is only taken while idle.
    assign accept = (state_reg == S_IDLE) && bus.start && (bus.op <= OP_DIVU);

    // Operand conditioning: signed ops run on magnitudes and fix signs at the end.
    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        if (bus.op == OP_MULT || bus.op == OP_DIV) begin
            a_neg = bus.rega[W-1];
            b_neg = bus.regb[W-1];
        end
        a_abs = a_neg ? (~bus.rega + 1'b1) : bus.rega;
        b_abs = b_neg ? (~bus.regb + 1'b1) : bus.regb;
    end

    // One iteration: shift-add for multiply, restoring shift-subtract for divide.
    always_comb begin
        mul_sum  = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opb_reg} : {(W+1){1'b0}});
        div_diff = {1'b0, acc_hi_reg, acc_lo_reg[W-1]} - {2'b00, opb_reg};
    end

    // Final sign correction and divide-by-zero substitution for write-back.
    always_comb begin
        prod_fixed = {acc_hi_reg, acc_lo_reg};
        if (sign_q_reg) begin
            prod_fixed = ~prod_fixed + 1'b1;
        end
        fix_hi = prod_fixed[2*W-1:W];
        fix_lo = prod_fixed[W-1:0];
        if (is_div_reg) begin
            if (b_zero_reg) begin
                fix_hi = orig_a_reg;
                fix_lo = {W{1'b1}};
            end else begin
                fix_hi = sign_r_reg ? (~acc_hi_reg + 1'b1) : acc_hi_reg;
                fix_lo = sign_q_reg ? (~acc_lo_reg + 1'b1) : acc_lo_reg;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> RUN for W edges -> FIX for one edge -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = S_RUN;
            S_RUN:  if (cnt_reg == CNT_BITS'(1)) state_next = S_FIX;
            S_FIX:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath, HI/LO and status registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg    <= '0;
            acc_hi_reg <= '0;
            acc_lo_reg <= '0;
            opb_reg    <= '0;
            orig_a_reg <= '0;
            is_div_reg <= 1'b0;
            b_zero_reg <= 1'b0;
            sign_q_reg <= 1'b0;
            sign_r_reg <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            done_reg   <= 1'b0;
            dbz_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        cnt_reg    <= CNT_BITS'(W);
                        acc_hi_reg <= '0;
                        acc_lo_reg <= (bus.op == OP_DIV || bus.op == OP_DIVU) ? a_abs : b_abs;
                        opb_reg    <= (bus.op == OP_DIV || bus.op == OP_DIVU) ? b_abs : a_abs;
                        orig_a_reg <= bus.rega;
                        is_div_reg <= (bus.op == OP_DIV || bus.op == OP_DIVU);
                        b_zero_reg <= (bus.regb == '0);
                        sign_q_reg <= a_neg ^ b_neg;
                        sign_r_reg <= a_neg;
                        dbz_reg    <= 1'b0;
                    end else if (bus.start && bus.op == OP_MTHI) begin
                        hi_reg <= bus.rega;
                    end else if (bus.start && bus.op == OP_MTLO) begin
                        lo_reg <= bus.rega;
                    end
                end
                S_RUN: begin
                    cnt_reg <= cnt_reg - 1'b1;
                    if (is_div_reg) begin
                        if (!div_diff[W+1]) begin
                            acc_hi_reg <= div_diff[W-1:0];
                            acc_lo_reg <= {acc_lo_reg[W-2:0], 1'b1};
                        end else begin
                            acc_hi_reg <= {acc_hi_reg[W-2:0], acc_lo_reg[W-1]};
                            acc_lo_reg <= {acc_lo_reg[W-2:0], 1'b0};
                        end
                    end else begin
                        acc_hi_reg <= mul_sum[W:1];
                        acc_lo_reg <= {mul_sum[0], acc_lo_reg[W-1:1]};
                    end
                end
                S_FIX: begin
                    hi_reg   <= fix_hi;
                    lo_reg   <= fix_lo;
                    done_reg <= 1'b1;
                    dbz_reg  <= is_div_reg && b_zero_reg;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state_reg != S_IDLE);
    assign bus.done        = done_reg;
    assign bus.hi          = hi_reg;
    assign bus.lo          = lo_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at DATA_WIDTH=16: vector table plus
// hand-written sequences for busy, MTHI/MTLO and mid-operation reset.
module tb_alu_muldiv;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    alu_muldiv_if #(.DATA_WIDTH(16)) bus ();

    alu_muldiv #(.DATA_WIDTH(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] hi;
        logic [15:0] lo;
        logic        dbz;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one arithmetic op and wait for done; checks latency, HI/LO hold and status.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input string tag);
        int          nbusy;
        logic        got;
        logic        held;
        logic [15:0] hi0, lo0;
        @(negedge clk);
        bus.op = op; bus.rega = a; bus.regb = b; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check({tag, " dbz_clear"}, {31'd0, bus.div_by_zero}, 32'd0);
        hi0 = bus.hi; lo0 = bus.lo;
        nbusy = 0; got = 1'b0; held = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            if (bus.busy) nbusy++;
            if (bus.hi !== hi0 || bus.lo !== lo0) held = 1'b0;
            @(negedge clk);
        end
        check({tag, " done_seen"}, {31'd0, got}, 32'd1);
        check({tag, " busy_cycles"}, nbusy, 32'd17);
        check({tag, " hold"}, {31'd0, held}, 32'd1);
        check({tag, " busy_at_done"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus.op = 3'd0; bus.rega = '0; bus.regb = '0; bus.start = 1'b0;

        vecs[0]  = '{3'd1, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0};
        vecs[1]  = '{3'd0, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0};
        vecs[2]  = '{3'd0, 16'h8000, 16'h8000, 16'h4000, 16'h0000, 1'b0};
        vecs[3]  = '{3'd2, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0};
        vecs[4]  = '{3'd2, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0};
        vecs[5]  = '{3'd3, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
        vecs[6]  = '{3'd3, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1};
        vecs[7]  = '{3'd1, 16'h1234, 16'h0010, 16'h0001, 16'h2340, 1'b0};
        vecs[8]  = '{3'd2, 16'h0007, 16'hFFFE, 16'h0001, 16'hFFFD, 1'b0};
        vecs[9]  = '{3'd2, 16'hFFF9, 16'h0000, 16'hFFF9, 16'hFFFF, 1'b1};
        vecs[10] = '{3'd3, 16'h03E8, 16'h0007, 16'h0006, 16'h008E, 1'b0};
        vecs[11] = '{3'd0, 16'h7FFF, 16'h7FFF, 16'h3FFF, 16'h0001, 1'b0};

        // Reset state.
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset hi", {16'd0, bus.hi}, 32'd0);
        check("reset lo", {16'd0, bus.lo}, 32'd0);
        check("reset busy", {31'd0, bus.busy}, 32'd0);
        check("reset done", {31'd0, bus.done}, 32'd0);
        check("reset dbz", {31'd0, bus.div_by_zero}, 32'd0);
        rst_n = 1'b1;

        // Table-driven arithmetic vectors.
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            $display("vec %0d op=%0d a=%h b=%h -> hi=%h lo=%h dbz=%0d", i, vecs[i].op,
                     vecs[i].a, vecs[i].b, bus.hi, bus.lo, bus.div_by_zero);
            check($sformatf("vec%0d hi", i), {16'd0, bus.hi}, {16'd0, vecs[i].hi});
            check($sformatf("vec%0d lo", i), {16'd0, bus.lo}, {16'd0, vecs[i].lo});
            check($sformatf("vec%0d dbz", i), {31'd0, bus.div_by_zero}, {31'd0, vecs[i].dbz});
            @(negedge clk);
            check($sformatf("vec%0d done_drop", i), {31'd0, bus.done}, 32'd0);
        end

        // Starts during busy (DIVU, then MTHI) are ignored.
        @(negedge clk);
        bus.op = 3'd1; bus.rega = 16'h0003; bus.regb = 16'h0004; bus.start = 1'b1;
        @(negedge clk);
        bus.op = 3'd3; bus.rega = 16'h5555; bus.regb = 16'h0000;
        repeat (3) @(negedge clk);
        bus.op = 3'd4;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        begin
            logic got;
            got = 1'b0;
            for (int k = 0; k < 40; k++) begin
                if (bus.done) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            check("busyseq done_seen", {31'd0, got}, 32'd1);
        end
        $display("busyseq MULTU 3*4 with ignored starts -> hi=%h lo=%h", bus.hi, bus.lo);
        check("busyseq hi", {16'd0, bus.hi}, 32'h0000);
        check("busyseq lo", {16'd0, bus.lo}, 32'h000C);
        check("busyseq dbz", {31'd0, bus.div_by_zero}, 32'd0);
        @(negedge clk);
        check("busyseq no_restart", {31'd0, bus.busy}, 32'd0);

        // MTHI / MTLO in IDLE: single edge, no busy, no done.
        bus.op = 3'd4; bus.rega = 16'hABCD; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        $display("MTHI rega=abcd -> hi=%h lo=%h", bus.hi, bus.lo);
        check("mthi hi", {16'd0, bus.hi}, 32'hABCD);
        check("mthi lo_kept", {16'd0, bus.lo}, 32'h000C);
        check("mthi busy", {31'd0, bus.busy}, 32'd0);
        check("mthi done", {31'd0, bus.done}, 32'd0);
        bus.op = 3'd5; bus.rega = 16'h5A5A; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        $display("MTLO rega=5a5a -> hi=%h lo=%h", bus.hi, bus.lo);
        check("mtlo lo", {16'd0, bus.lo}, 32'h5A5A);
        check("mtlo hi_kept", {16'd0, bus.hi}, 32'hABCD);

        // Reserved op is ignored.
        bus.op = 3'd6; bus.rega = 16'h1111; bus.regb = 16'h2222; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        $display("reserved op 6 -> busy=%0d hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
        check("rsvd busy", {31'd0, bus.busy}, 32'd0);
        check("rsvd hi", {16'd0, bus.hi}, 32'hABCD);
        check("rsvd lo", {16'd0, bus.lo}, 32'h5A5A);

        // Reset mid-operation: DIVU started, rst_n low at E8.
        bus.op = 3'd3; bus.rega = 16'h1234; bus.regb = 16'h0003; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        check("midrst busy_before", {31'd0, bus.busy}, 32'd1);
        check("midrst hi_held", {16'd0, bus.hi}, 32'hABCD);
        rst_n = 1'b0;
        @(negedge clk);
        $display("reset at E8 -> hi=%h lo=%h busy=%0d done=%0d", bus.hi, bus.lo, bus.busy, bus.done);
        check("midrst hi", {16'd0, bus.hi}, 32'd0);
        check("midrst lo", {16'd0, bus.lo}, 32'd0);
        check("midrst busy", {31'd0, bus.busy}, 32'd0);
        check("midrst done", {31'd0, bus.done}, 32'd0);
        rst_n = 1'b1;

        run_op(3'd0, 16'h0002, 16'hFFFF, "post_rst");
        $display("MULT 2*(-1) -> hi=%h lo=%h", bus.hi, bus.lo);
        check("post_rst hi", {16'd0, bus.hi}, 32'hFFFF);
        check("post_rst lo", {16'd0, bus.lo}, 32'hFFFE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule
